// File: rtl/in_class_pkg.sv
// in_class_pkg: shared op encoding, logic-op helper and result payload type
package in_class_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {LOP_AND, LOP_OR, LOP_XOR, LOP_NAND} lop_e;
  typedef struct packed {
    logic [MAX_W-1:0] x;
    logic [MAX_W-1:0] y;
    logic [MAX_W-1:0] z;
    logic [1:0]       carry;
  } payload_t;
  function automatic logic [MAX_W-1:0] lop_apply(lop_e op, logic [MAX_W-1:0] a, logic [MAX_W-1:0] b);
    return op == LOP_AND ? a & b : op == LOP_OR ? a | b : op == LOP_XOR ? a ^ b : ~(a & b);
  endfunction
endpackage

// File: rtl/in_class_pipe_slice.sv
// in_class_pipe_slice: one valid/ready register slice, full throughput
module in_class_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/in_class_pipe.sv
// in_class_pipe: pipelined three-operand datapath (logic op, 3-way sum, running accumulator)
module in_class_pipe
  import in_class_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int STAGES  = 2,
  parameter int ACC_SAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic [1:0]       carry
);
  localparam int PW = 3*WIDTH + 2;
  logic [WIDTH-1:0]           acc, acc_base, acc_next;
  logic [WIDTH:0]             acc_sum;
  logic [WIDTH+1:0]           sum;
  logic                       accept;
  logic [STAGES:0]            v, r;
  logic [STAGES:0][PW-1:0]    d;
  assign accept   = in_valid && in_ready;
  assign in_ready = reset && r[0];
  assign sum      = (WIDTH+2)'(a) + (WIDTH+2)'(b) + (WIDTH+2)'(c);
  assign acc_base = acc_clear ? '0 : acc;
  assign acc_sum  = (WIDTH+1)'(acc_base) + (WIDTH+1)'(c);
  assign acc_next = (ACC_SAT != 0 && acc_sum[WIDTH]) ? '1 : acc_sum[WIDTH-1:0];
  assign v[0]      = in_valid;
  assign d[0]      = {sum[WIDTH+1:WIDTH], acc_next, sum[WIDTH-1:0], WIDTH'(lop_apply(lop_e'(mode), MAX_W'(a), MAX_W'(b)))};
  assign r[STAGES] = out_ready;
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_slice
      in_class_pipe_slice #(.W(PW)) u_slice (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v[k]),
        .in_ready  (r[k]),
        .in_data   (d[k]),
        .out_valid (v[k+1]),
        .out_ready (r[k+1]),
        .out_data  (d[k+1])
      );
    end
  endgenerate
  assign out_valid          = v[STAGES];
  assign {carry, z, y, x}   = d[STAGES];
  // a clear with no accepted beat still empties the accumulator
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (accept || acc_clear) acc <= accept ? acc_next : '0;
endmodule

// File: tb/tb_in_class_pipe.sv
// tb_in_class_pipe: random/directed bench with queue-based reference model; saturating and wrapping instances side by side
module tb_in_class_pipe;
  import in_class_pkg::*;
  localparam int STAGES = 2;
  typedef struct {
    payload_t    p;
    logic [15:0] zw;
    int          t;
  } item_t;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, acc_clear = 1'b0, out_ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] a = '0, b = '0, c = '0;
  logic        ir0, ov0, ir1, ov1;
  logic [15:0] x0, y0, z0, x1, y1, z1;
  logic [1:0]  cy0, cy1;

  item_t       q[$];
  int          n_chk = 0, n_fail = 0, cyc = 0, n_emit = 0;
  int unsigned acc_s = 0, acc_w = 0;
  logic [15:0] lx, ly, lz, lzw;
  logic [1:0]  lcy;

  always #5 clk = ~clk;

  in_class_pipe #(.WIDTH(16), .STAGES(STAGES), .ACC_SAT(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .mode(mode),
    .a(a), .b(b), .c(c), .acc_clear(acc_clear), .out_valid(ov0), .out_ready(out_ready),
    .x(x0), .y(y0), .z(z0), .carry(cy0));
  in_class_pipe #(.WIDTH(16), .STAGES(STAGES), .ACC_SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .mode(mode),
    .a(a), .b(b), .c(c), .acc_clear(acc_clear), .out_valid(ov1), .out_ready(out_ready),
    .x(x1), .y(y1), .z(z1), .carry(cy1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check against the model, then account for the coming posedge
  task automatic cycle(input logic iv, input logic [1:0] m, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ic, input logic clr, input logic ordy, output logic got);
    logic exp_ov, exp_ir;
    item_t it;
    int unsigned base, s;
    @(negedge clk);
    in_valid = iv; mode = m; a = ia; b = ib; c = ic; acc_clear = clr; out_ready = ordy;
    #1;
    exp_ov = q.size() > 0 && (cyc - q[0].t) >= STAGES;
    exp_ir = !(q.size() == STAGES && !ordy);
    chk("in_ready_sat", 64'(ir0), 64'(exp_ir));
    chk("in_ready_wrap", 64'(ir1), 64'(exp_ir));
    chk("out_valid_sat", 64'(ov0), 64'(exp_ov));
    chk("out_valid_wrap", 64'(ov1), 64'(exp_ov));
    if (exp_ov) begin
      chk("x", 64'(x0), q[0].p.x);
      chk("y", 64'(y0), q[0].p.y);
      chk("carry", 64'(cy0), 64'(q[0].p.carry));
      chk("z_sat", 64'(z0), q[0].p.z);
      chk("x_wrap", 64'(x1), q[0].p.x);
      chk("y_wrap", 64'(y1), q[0].p.y);
      chk("carry_wrap", 64'(cy1), 64'(q[0].p.carry));
      chk("z_wrap", 64'(z1), 64'(q[0].zw));
      if (ordy) begin
        lx = x0; ly = y0; lz = z0; lzw = z1; lcy = cy0;
        void'(q.pop_front());
        n_emit++;
      end
    end
    got = iv && exp_ir;
    if (got) begin
      case (m)
        2'd0:    it.p.x = 64'(ia & ib);
        2'd1:    it.p.x = 64'(ia | ib);
        2'd2:    it.p.x = 64'(ia ^ ib);
        default: it.p.x = 64'(16'(~(ia & ib)));
      endcase
      s = int'(ia) + int'(ib) + int'(ic);
      it.p.y = 64'(s % 65536);
      it.p.carry = 2'(s / 65536);
      base = clr ? 0 : acc_s;
      acc_s = (base + ic > 65535) ? 65535 : base + ic;
      base = clr ? 0 : acc_w;
      acc_w = (base + ic) % 65536;
      it.p.z = 64'(acc_s);
      it.zw = 16'(acc_w);
      it.t = cyc;
      q.push_back(it);
    end else if (clr) begin
      acc_s = 0;
      acc_w = 0;
    end
    cyc++;
  endtask

  task automatic issue(input logic [1:0] m, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] ic, input logic clr, input bit rnd);
    logic got = 1'b0;
    for (int n = 0; n < 64 && !got; n++)
      cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, m, ia, ib, ic, clr,
            rnd ? ($urandom_range(0, 3) != 0) : 1'b1, got);
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    logic got;
    for (int n = 0; n < 40 && q.size() > 0; n++) cycle(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, got);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic beat(input logic [1:0] m, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [15:0] ic, input logic clr);
    issue(m, ia, ib, ic, clr, 1'b0);
    drain();
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   k, emit0;
    logic [15:0] rc;
    // reset held with clock running
    #100;
    @(negedge clk);
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_in_ready", 64'(ir0), 64'd0);
    chk("rst_x", 64'(x0), 64'd0);
    chk("rst_y", 64'(y0), 64'd0);
    chk("rst_z", 64'(z0), 64'd0);
    chk("rst_carry", 64'(cy0), 64'd0);
    chk("rst_out_valid_wrap", 64'(ov1), 64'd0);
    chk("rst_in_ready_wrap", 64'(ir1), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 64'(ir0), 64'd1);
    chk("rel_in_ready_wrap", 64'(ir1), 64'd1);

    beat(2'd0, 16'h00FF, 16'h0F0F, 16'h0001, 1'b0);
    chk("and_x", 64'(lx), 64'h000F);
    chk("and_y", 64'(ly), 64'h100F);
    chk("and_carry", 64'(lcy), 64'd0);
    chk("and_z", 64'(lz), 64'h0001);

    beat(2'd2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("xor_x", 64'(lx), 64'h0000);
    chk("xor_y", 64'(ly), 64'hFFFD);
    chk("xor_carry", 64'(lcy), 64'd2);
    beat(2'd3, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    chk("nand_x", 64'(lx), 64'h0000);

    beat(2'd0, 16'h0, 16'h0, 16'h8000, 1'b1);
    chk("acc1_sat", 64'(lz), 64'h8000);
    chk("acc1_wrap", 64'(lzw), 64'h8000);
    beat(2'd0, 16'h0, 16'h0, 16'h8000, 1'b0);
    chk("acc2_sat", 64'(lz), 64'hFFFF);
    chk("acc2_wrap", 64'(lzw), 64'h0000);
    beat(2'd0, 16'h0, 16'h0, 16'h0001, 1'b0);
    chk("acc3_sat", 64'(lz), 64'hFFFF);
    chk("acc3_wrap", 64'(lzw), 64'h0001);

    // six-beat stream with a four-cycle sink stall
    k = 0;
    emit0 = n_emit;
    for (int t = 1; t <= 12; t++) begin
      cycle(k < 6, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 255)),
            1'b0, !(t >= 3 && t <= 6), got);
      if (got) k++;
    end
    drain();
    chk("stream_emitted", 64'(n_emit - emit0), 64'd6);
    beat(2'd1, 16'h1234, 16'h0000, 16'd5, 1'b1);
    chk("clear_z_sat", 64'(lz), 64'd5);
    chk("clear_z_wrap", 64'(lzw), 64'd5);

    // sweep with random handshakes and a reset in the middle
    for (int i = 0; i < 65536; i += 97) begin
      issue(2'($urandom_range(0, 3)), 16'(i), 16'(~i), 16'($urandom), 1'b0, 1'b1);
      if (i == 97 * 340) begin
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(ov0), 64'd0);
        chk("midrst_out_valid_wrap", 64'(ov1), 64'd0);
        chk("midrst_in_ready", 64'(ir0), 64'd0);
        q.delete();
        acc_s = 0;
        acc_w = 0;
        in_valid = 1'b0;
        acc_clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rc = 16'($urandom);
        beat(2'd2, 16'(i), 16'(~i), rc, 1'b0);
        chk("restart_z_sat", 64'(lz), 64'(rc));
        chk("restart_z_wrap", 64'(lzw), 64'(rc));
      end
    end
    issue(2'd3, 16'hFFFF, 16'h0000, 16'($urandom), 1'b0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
